// File: rtl/eth_reg_arbiter.sv
// Two-master round-robin arbiter onto the Ethernet block register port.
// One transaction in flight; reads that never answer end in a timeout.
module eth_reg_arbiter #(
  parameter int REG_AWIDTH = 14,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_req_valid,
  input  logic                  a_req_wr,
  input  logic [REG_AWIDTH-1:0] a_req_addr,
  input  logic [31:0]           a_req_wdata,
  output logic                  a_req_ready,
  output logic                  a_resp_valid,
  output logic [31:0]           a_resp_data,
  output logic                  a_resp_err,
  input  logic                  b_req_valid,
  input  logic                  b_req_wr,
  input  logic [REG_AWIDTH-1:0] b_req_addr,
  input  logic [31:0]           b_req_wdata,
  output logic                  b_req_ready,
  output logic                  b_resp_valid,
  output logic [31:0]           b_resp_data,
  output logic                  b_resp_err,
  output logic                  reg_wr_req,
  output logic [REG_AWIDTH-1:0] reg_wr_addr,
  output logic [31:0]           reg_wr_data,
  output logic                  reg_rd_req,
  output logic [REG_AWIDTH-1:0] reg_rd_addr,
  input  logic                  reg_rd_resp,
  input  logic [31:0]           reg_rd_data,
  output logic                  busy,
  output logic [7:0]            timeout_count
);

  localparam logic [7:0] TMO = 8'(RD_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                  last_b;
  logic                  grant_b;
  logic [REG_AWIDTH-1:0] lat_addr;
  logic [31:0]           lat_wdata;
  logic [31:0]           rsp_data;
  logic                  rsp_err;
  logic [7:0]            wait_cnt;

  logic                  a_sel;
  logic                  b_sel;
  logic                  accept;
  logic                  sel_wr;
  logic [REG_AWIDTH-1:0] sel_addr;
  logic [31:0]           sel_wdata;
  logic                  waiting;
  logic                  rd_hit;
  logic                  rd_tmo;

  // Contention goes to whoever was not granted last.
  assign a_sel = a_req_valid && (!b_req_valid || last_b);
  assign b_sel = b_req_valid && (!a_req_valid || !last_b);

  assign a_req_ready = (state == IDLE) && a_sel;
  assign b_req_ready = (state == IDLE) && b_sel;
  assign accept      = a_req_ready || b_req_ready;

  assign sel_wr    = b_sel ? b_req_wr    : a_req_wr;
  assign sel_addr  = b_sel ? b_req_addr  : a_req_addr;
  assign sel_wdata = b_sel ? b_req_wdata : a_req_wdata;

  // The issue cycle is the one READ cycle with reg_rd_req high.
  assign waiting = (state == READ) && !reg_rd_req;
  assign rd_hit  = waiting && reg_rd_resp;
  assign rd_tmo  = waiting && !reg_rd_resp && (wait_cnt == TMO);

  assign busy = (state != IDLE);

  assign reg_wr_addr = lat_addr;
  assign reg_wr_data = lat_wdata;
  assign reg_rd_addr = lat_addr;

  assign a_resp_valid = (state == DONE) && !grant_b;
  assign b_resp_valid = (state == DONE) && grant_b;
  assign a_resp_data  = a_resp_valid ? rsp_data : 32'h0;
  assign b_resp_data  = b_resp_valid ? rsp_data : 32'h0;
  assign a_resp_err   = a_resp_valid && rsp_err;
  assign b_resp_err   = b_resp_valid && rsp_err;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = sel_wr ? WRITE : READ;
      end
      WRITE: state_nxt = DONE;
      READ: begin
        if (rd_hit || rd_tmo) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant history and request latches, loaded on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_b    <= 1'b1;
      grant_b   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      last_b    <= b_sel;
      grant_b   <= b_sel;
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
    end
  end

  // Downstream strobes: one cycle right after accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_wr_req <= 1'b0;
      reg_rd_req <= 1'b0;
    end else begin
      reg_wr_req <= accept && sel_wr;
      reg_rd_req <= accept && !sel_wr;
    end
  end

  // Read wait counter, counting from the cycle after issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     wait_cnt <= '0;
    else if (waiting) wait_cnt <= wait_cnt + 8'd1;
    else              wait_cnt <= '0;
  end

  // Response payload for the DONE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (rd_hit) begin
      rsp_data <= reg_rd_data;
    end else if (rd_tmo) begin
      rsp_err  <= 1'b1;
    end
  end

  // Saturating read-timeout statistic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_count <= '0;
    end else if (rd_tmo && timeout_count != 8'hFF) begin
      timeout_count <= timeout_count + 8'd1;
    end
  end

endmodule
